// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for timed output blocks: state encoding and tick constants at 100 MHz.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int unsigned TICKS_1MS   = 100_000;
  localparam int unsigned TICKS_125MS = 12_500_000;
  localparam int unsigned TICKS_250MS = 25_000_000;

endpackage

// File: rtl/pulse_stretcher_tick_timer.sv
// Loadable down-counter that stops at zero; zero flags expiry.
// Latency: load takes effect at the next edge; zero is combinational from count.
// Backpressure: none; en freezes the count.
module tick_timer #(
  parameter int W = 27
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load wins over counting; the count never wraps below zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle trigger pulses into timed high levels with a minimum low holdoff, queueing extras.
// Latency: level_out rises one cycle after an accepted trigger; all outputs registered.
// Backpressure: none; requests beyond the queue depth are discarded and flagged on dropped.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_TICKS  = 25_000_000,
  parameter int OFF_TICKS = 12_500_000,
  parameter int CNT_W     = 27,
  parameter int PEND_W    = 3,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger_in,
  input  logic              abort,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              dropped
);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             state, state_nx;
  logic               trig;
  logic               q_req;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]   tmr_val, tmr_count;
  logic [PEND_W-1:0]  pend_nx;
  logic               drop_nx;

  // abort masks any trigger in the same cycle
  assign trig = trigger_in & ~abort;

  tick_timer #(.W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Next state, timer control and queue bookkeeping.
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = ON_LOAD;
    tmr_en   = (state != ST_IDLE) && (tmr_count != '0);
    q_req    = 1'b0;
    pend_nx  = pending;
    drop_nx  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nx = ST_ON;
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      ST_ON: begin
        if (abort) begin
          state_nx = ST_OFF;
          tmr_load = 1'b1;
          tmr_val  = OFF_LOAD;
          pend_nx  = '0;
        end else if (trig && RETRIGGER) begin
          // extend the pulse; also covers the terminal cycle, so we stay in ON
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end else begin
          q_req = trig;
          if (tmr_zero) begin
            state_nx = ST_OFF;
            tmr_load = 1'b1;
            tmr_val  = OFF_LOAD;
          end
        end
      end
      ST_OFF: begin
        if (abort) begin
          pend_nx = '0;
          if (tmr_zero) state_nx = ST_IDLE;
        end else if (tmr_zero) begin
          if ((pending != '0) || trig) begin
            state_nx = ST_ON;
            tmr_load = 1'b1;
            tmr_val  = ON_LOAD;
            // a coincident trigger replaces the request being served
            if (!trig) pend_nx = pending - 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          q_req = trig;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (q_req) begin
      if (pending == PEND_MAX) drop_nx = 1'b1;
      else                     pend_nx = pending + 1'b1;
    end
  end

  // State and registered outputs, derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      level_out <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nx;
      level_out <= (state_nx == ST_ON);
      busy      <= (state_nx != ST_IDLE);
      pending   <= pend_nx;
      dropped   <= drop_nx;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON_TICKS=4, OFF_TICKS=3, PEND_W=2.
// Latency: cycle n is the interval after the n-th edge since reset release.
// Backpressure: n/a.
module tb_pulse_stretcher;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger_in = 1'b0;
  logic       abort = 1'b0;
  logic       lvl0, bsy0, drp0;
  logic [1:0] pnd0;
  logic       lvl1, bsy1, drp1;
  logic [1:0] pnd1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  pulse_stretcher #(.ON_TICKS(4), .OFF_TICKS(3), .CNT_W(3), .PEND_W(2), .RETRIGGER(1'b0)) dut0 (
    .clock(clock), .reset(reset), .trigger_in(trigger_in), .abort(abort),
    .level_out(lvl0), .busy(bsy0), .pending(pnd0), .dropped(drp0)
  );

  pulse_stretcher #(.ON_TICKS(4), .OFF_TICKS(3), .CNT_W(3), .PEND_W(2), .RETRIGGER(1'b1)) dut1 (
    .clock(clock), .reset(reset), .trigger_in(trigger_in), .abort(abort),
    .level_out(lvl1), .busy(bsy1), .pending(pnd1), .dropped(drp1)
  );

  task automatic step(input logic t, input logic a);
    trigger_in = t;
    abort      = a;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trigger_in = 1'b0;
    abort = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  // observed/expected packed as {level_out, busy, pending, dropped}
  task automatic chk(input string tag, input int which, input logic l, input logic b,
                     input logic [1:0] p, input logic d);
    logic [4:0] obs, exp;
    obs = (which == 0) ? {lvl0, bsy0, pnd0, drp0} : {lvl1, bsy1, pnd1, drp1};
    exp = {l, b, p, d};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] p;
    int ph;

    // single trigger
    do_reset();
    chk("reset_state", 0, 1'b0, 1'b0, 2'd0, 1'b0);
    run_to(10);
    step(1'b1, 1'b0);
    for (int c = 11; c <= 18; c++) begin
      chk("single", 0, (c <= 14), (c <= 17), 2'd0, 1'b0);
      step(1'b0, 1'b0);
    end

    // queue of three, then an overflow trigger during holdoff
    do_reset();
    run_to(10);
    step(1'b1, 1'b0);
    for (int c = 11; c <= 40; c++) begin
      ph = (c - 11) % 7;
      if      (c <= 11) p = 2'd0;
      else if (c == 12) p = 2'd1;
      else if (c == 13) p = 2'd2;
      else if (c <= 17) p = 2'd3;
      else if (c <= 24) p = 2'd2;
      else if (c <= 31) p = 2'd1;
      else              p = 2'd0;
      chk("queue", 0, (c <= 38) && (ph < 4), (c <= 38), p, (c == 16));
      step((c == 11) || (c == 12) || (c == 13) || (c == 15), 1'b0);
    end

    // retrigger extends a single pulse
    do_reset();
    run_to(10);
    step(1'b1, 1'b0);
    for (int c = 11; c <= 22; c++) begin
      chk("retrig", 1, (c <= 18), (c <= 21), 2'd0, 1'b0);
      step((c == 12) || (c == 14), 1'b0);
    end

    // abort during ON with two queued and a coincident trigger
    do_reset();
    run_to(9);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("abort_pre", 0, 1'b1, 1'b1, 2'd2, 1'b0);
    step(1'b1, 1'b1);
    for (int c = 13; c <= 20; c++) begin
      chk("abort", 0, 1'b0, (c <= 15), 2'd0, 1'b0);
      step(1'b0, 1'b0);
    end

    // trigger exactly at holdoff expiry, nothing queued
    do_reset();
    run_to(10);
    step(1'b1, 1'b0);
    run_to(17);
    chk("expiry0_off", 0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b0);
    chk("expiry0_on", 0, 1'b1, 1'b1, 2'd0, 1'b0);
    run_to(22);
    chk("expiry0_off2", 0, 1'b0, 1'b1, 2'd0, 1'b0);
    run_to(25);
    chk("expiry0_idle", 0, 1'b0, 1'b0, 2'd0, 1'b0);

    // trigger exactly at holdoff expiry, one queued
    do_reset();
    run_to(10);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run_to(17);
    chk("expiry1_off", 0, 1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b1, 1'b0);
    chk("expiry1_on", 0, 1'b1, 1'b1, 2'd1, 1'b0);
    run_to(25);
    chk("expiry1_serve", 0, 1'b1, 1'b1, 2'd0, 1'b0);

    // reset in the middle of a pulse with two queued
    do_reset();
    run_to(10);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_pre", 0, 1'b1, 1'b1, 2'd2, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
    for (int c = 14; c <= 30; c++) begin
      chk("rst_mid", 0, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
